vp_instr_encoder: RTL and testbench

Instruction encoder and program loader for the vector processor. It accepts field-level instruction requests over a valid/ready handshake, packs each one into the 32-bit ISA word that the decode stage consumes, and buffers the words in a small FIFO. It then writes them to consecutive instruction-memory addresses through a stallable write port. It is used by the test/boot path to build programs in IMEM without hand-assembled hex.

---
 rtl/vp_isa_pkg.sv | 32 +++
 rtl/vp_sync_fifo.sv | 73 +++++++
 rtl/vp_instr_encoder.sv | 196 +++++++++++++++++++
 tb/tb_vp_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_isa_pkg.sv
// ISA constants shared by the instruction encoder and the decode stage:
// opcodes, request classes and instruction-word field positions.
package vp_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b101010;
    localparam logic [5:0] OP_LD    = 6'b100000;
    localparam logic [5:0] OP_SD    = 6'b100001;
    localparam logic [5:0] OP_VBNZ  = 6'b100010;
    localparam logic [5:0] OP_VBEZ  = 6'b100011;
    localparam logic [5:0] OP_NOP   = 6'b111100;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_LD    = 3'd1,
        CLS_SD    = 3'd2,
        CLS_VBNZ  = 3'd3,
        CLS_VBEZ  = 3'd4,
        CLS_NOP   = 3'd5,
        CLS_ILL6  = 3'd6,
        CLS_ILL7  = 3'd7
    } req_class_e;

    localparam int OP_LSB   = 26;
    localparam int RD_LSB   = 21;
    localparam int RA_LSB   = 16;
    localparam int RB_LSB   = 11;
    localparam int PPP_LSB  = 8;
    localparam int WW_LSB   = 6;
    localparam int FUNC_LSB = 0;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/vp_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, registered occupancy.
// Ports: clk, reset, push/wdata, pop/rdata, full, empty, count.
module vp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pop is qualified on registered occupancy; push may share a cycle
    // with pop, but never lands on a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vp_instr_encoder.sv
// Packs field-level instruction requests into ISA words, queues them
// and writes them to consecutive IMEM addresses.
// Ports: prog_start/prog_base start a program; req_* valid/ready
// request channel; imem_* stallable write port; busy, prog_done,
// err_illegal status pulses; instr_count words written this program.
module vp_instr_encoder
    import vp_isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_start,
    input  logic [ADDR_W-1:0] prog_base,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [2:0]        req_class,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_ra,
    input  logic [4:0]        req_rb,
    input  logic [2:0]        req_ppp,
    input  logic [1:0]        req_ww,
    input  logic [5:0]        req_func,
    input  logic [15:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              prog_done,
    output logic              err_illegal,
    output logic [ADDR_W:0]   instr_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IC_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IC_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              accept, legal, push, wr_done, active;
    logic [31:0]       enc_word, fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Memory and branch classes put their single register in the
    // rd slot [25:21]; the "ra" naming is the assembler's view.
    function automatic logic [31:0] encode(
        input logic [2:0]  cls,
        input logic [4:0]  rd,
        input logic [4:0]  ra,
        input logic [4:0]  rb,
        input logic [2:0]  ppp,
        input logic [1:0]  ww,
        input logic [5:0]  func,
        input logic [15:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (req_class_e'(cls))
            CLS_RTYPE: begin
                w[OP_LSB +: 6]   = OP_RTYPE;
                w[RD_LSB +: 5]   = rd;
                w[RA_LSB +: 5]   = ra;
                w[RB_LSB +: 5]   = rb;
                w[PPP_LSB +: 3]  = ppp;
                w[WW_LSB +: 2]   = ww;
                w[FUNC_LSB +: 6] = func;
            end
            CLS_LD: begin
                w[OP_LSB +: 6]   = OP_LD;
                w[RD_LSB +: 5]   = rd;
                w[IMM_LSB +: 16] = imm;
            end
            CLS_SD: begin
                w[OP_LSB +: 6]   = OP_SD;
                w[RD_LSB +: 5]   = ra;
                w[IMM_LSB +: 16] = imm;
            end
            CLS_VBNZ: begin
                w[OP_LSB +: 6]   = OP_VBNZ;
                w[RD_LSB +: 5]   = ra;
                w[IMM_LSB +: 16] = imm;
            end
            CLS_VBEZ: begin
                w[OP_LSB +: 6]   = OP_VBEZ;
                w[RD_LSB +: 5]   = ra;
                w[IMM_LSB +: 16] = imm;
            end
            CLS_NOP: begin
                w[OP_LSB +: 6] = OP_NOP;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    assign enc_word = encode(req_class, req_rd, req_ra, req_rb,
                             req_ppp, req_ww, req_func, req_imm);

    // Classes 6 and 7 are the only encodings with both upper bits set.
    assign legal   = !(req_class[2] && req_class[1]);
    assign active  = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign accept  = req_valid && req_ready;
    assign push    = accept && legal;
    assign wr_done = imem_we && imem_ready;

    vp_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (enc_word),
        .pop   (wr_done),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign req_ready   = (state_q == S_LOAD) && !fifo_full;
    assign imem_we     = active && !fifo_empty;
    assign imem_addr   = addr_q;
    assign imem_wdata  = active ? fifo_rdata : '0;
    assign busy        = (state_q != S_IDLE);
    assign prog_done   = (state_q == S_DONE);
    assign err_illegal = err_q;
    assign instr_count = cnt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = accept && !legal;
        unique case (state_q)
            S_IDLE: begin
                if (prog_start) begin
                    state_d = S_LOAD;
                    addr_d  = prog_base;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept && req_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leave as the final write retires so prog_done
                // follows the last completion by one cycle.
                if (fifo_empty ||
                    (fifo_count == CNT_W'(1) && wr_done)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (wr_done) begin
            addr_d = addr_q + ADDR_W'(1);
            if (cnt_q != '1) begin
                cnt_d = cnt_q + IC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_vp_instr_encoder.sv
// Directed bench for vp_instr_encoder with a write scoreboard.
// Expected IMEM writes are queued at request time, checked on completion.
module tb_vp_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_start;
    logic [7:0]  prog_base;
    logic        req_valid;
    logic        req_ready;
    logic        req_last;
    logic [2:0]  req_class;
    logic [4:0]  req_rd, req_ra, req_rb;
    logic [2:0]  req_ppp;
    logic [1:0]  req_ww;
    logic [5:0]  req_func;
    logic [15:0] req_imm;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        busy, prog_done, err_illegal;
    logic [8:0]  instr_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    int          wr_mark;
    logic [7:0]  exp_addr;
    logic [39:0] sb [$];

    vp_instr_encoder #(
        .DEPTH  (4),
        .ADDR_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_start  (prog_start),
        .prog_base   (prog_base),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_last    (req_last),
        .req_class   (req_class),
        .req_rd      (req_rd),
        .req_ra      (req_ra),
        .req_rb      (req_rb),
        .req_ppp     (req_ppp),
        .req_ww      (req_ww),
        .req_func    (req_func),
        .req_imm     (req_imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_ready  (imem_ready),
        .busy        (busy),
        .prog_done   (prog_done),
        .err_illegal (err_illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ld_word(input logic [4:0] rd,
                                            input logic [15:0] imm);
        return {6'b100000, rd, 5'b00000, imm};
    endfunction

    // Each completed write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && imem_we && imem_ready) begin
            logic had;
            n_wr++;
            had = (sb.size() != 0);
            chk("wr_expected", 64'(had), 64'd1);
            if (had) begin
                chk("wr", 64'({imem_addr, imem_wdata}),
                    64'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] base);
        prog_start = 1'b1;
        prog_base  = base;
        tick();
        prog_start = 1'b0;
        exp_addr   = base;
    endtask

    task automatic send(input logic [2:0] cls, input logic [4:0] rd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic [2:0] ppp, input logic [1:0] ww,
                        input logic [5:0] func, input logic [15:0] imm,
                        input logic last, input logic [31:0] exp_w);
        logic got;
        req_class = cls;
        req_rd    = rd;
        req_ra    = ra;
        req_rb    = rb;
        req_ppp   = ppp;
        req_ww    = ww;
        req_func  = func;
        req_imm   = imm;
        req_last  = last;
        req_valid = 1'b1;
        if (cls < 3'd6) begin
            sb.push_back({exp_addr, exp_w});
            exp_addr = exp_addr + 8'd1;
        end
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (req_ready) got = 1'b1;
            tick();
        end
        chk("send_accept", 64'(got), 64'd1);
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic send_ld(input logic [4:0] rd, input logic [15:0] imm,
                           input logic last);
        send(3'd1, rd, 5'd0, 5'd0, 3'd0, 2'd0, 6'd0, imm, last,
             ld_word(rd, imm));
    endtask

    task automatic send_nop(input logic last);
        send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 2'd0, 6'd0, 16'd0, last,
             32'hF000_0000);
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (prog_done) got = 1'b1;
            else tick();
        end
        chk(tag, 64'(got), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_prog_done"}, 64'(prog_done), 64'd0);
        chk({tag, "_err_illegal"}, 64'(err_illegal), 64'd0);
        chk({tag, "_instr_count"}, 64'(instr_count), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        prog_start = 1'b0;
        prog_base  = 8'd0;
        req_valid  = 1'b0;
        req_last   = 1'b0;
        req_class  = 3'd0;
        req_rd     = 5'd0;
        req_ra     = 5'd0;
        req_rb     = 5'd0;
        req_ppp    = 3'd0;
        req_ww     = 2'd0;
        req_func   = 6'd0;
        req_imm    = 16'd0;
        imem_ready = 1'b1;
        exp_addr   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        // Single R-type; start coincides with reset release.
        reset = 1'b0;
        start(8'h10);
        chk("busy_after_start", 64'(busy), 64'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 2'b01, 6'b000001, 16'd0,
             1'b1, 32'hA861_1041);
        chk("we_latency", 64'(imem_we), 64'd1);
        tick();
        chk("done_timing", 64'(prog_done), 64'd1);
        chk("count_one", 64'(instr_count), 64'd1);
        tick();
        chk("done_pulse", 64'(prog_done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Mixed classes at consecutive addresses.
        start(8'h20);
        send_ld(5'd5, 16'h0010, 1'b0);
        send(3'd2, 5'd0, 5'd4, 5'd0, 3'd0, 2'd0, 6'd0, 16'h0020, 1'b0,
             32'h8480_0020);
        send(3'd3, 5'd0, 5'd7, 5'd0, 3'd0, 2'd0, 6'd0, 16'hFFFC, 1'b0,
             32'h88E0_FFFC);
        send_nop(1'b1);
        wait_done("done_mixed");
        chk("count_mixed", 64'(instr_count), 64'd4);

        // Burst of 6 against a stalled IMEM.
        wr_mark = n_wr;
        start(8'h40);
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_ld(5'(i), 16'(i), 1'b0);
        end
        chk("ready_full", 64'(req_ready), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("stall_we", 64'(imem_we), 64'd1);
            chk("stall_addr", 64'(imem_addr), 64'h40);
            chk("stall_data", 64'(imem_wdata), 64'(ld_word(5'd0, 16'd0)));
            tick();
        end
        imem_ready = 1'b1;
        send_ld(5'd4, 16'd4, 1'b0);
        send_ld(5'd5, 16'd5, 1'b1);
        wait_done("done_burst");
        chk("burst_writes", 64'(n_wr - wr_mark), 64'd6);
        chk("count_burst", 64'(instr_count), 64'd6);

        // Address counter wraps past 0xFF.
        start(8'hFE);
        send_ld(5'd1, 16'hAAAA, 1'b0);
        send_ld(5'd2, 16'hBBBB, 1'b0);
        send_ld(5'd3, 16'hCCCC, 1'b1);
        wait_done("done_wrap");
        chk("wrap_addr", 64'(imem_addr), 64'h01);
        chk("count_wrap", 64'(instr_count), 64'd3);

        // Illegal class between two NOPs is dropped and flagged.
        wr_mark = n_wr;
        start(8'h50);
        send_nop(1'b0);
        send(3'd6, 5'd9, 5'd9, 5'd9, 3'd7, 2'd3, 6'h3F, 16'h1234, 1'b0,
             32'd0);
        chk("err_pulse", 64'(err_illegal), 64'd1);
        send_nop(1'b1);
        chk("err_pulse_end", 64'(err_illegal), 64'd0);
        wait_done("done_illegal");
        chk("illegal_writes", 64'(n_wr - wr_mark), 64'd2);
        chk("count_illegal", 64'(instr_count), 64'd2);

        // Reset with three words queued discards everything.
        start(8'h60);
        imem_ready = 1'b0;
        send_ld(5'd1, 16'd1, 1'b0);
        send_ld(5'd2, 16'd2, 1'b0);
        send_ld(5'd3, 16'd3, 1'b0);
        chk("queued_we", 64'(imem_we), 64'd1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        tick();
        reset      = 1'b0;
        imem_ready = 1'b1;
        wr_mark    = n_wr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_we", 64'(imem_we), 64'd0);
        end
        chk("post_rst_writes", 64'(n_wr - wr_mark), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
